// File: rtl/conv_kxk_acc.sv
// KxK multi-channel 2-D convolution accumulator: one kernel tap per cycle across the whole output map.
// Optional macro CONV_RELU_EN clamps negative ofm elements to zero on the output path.
module conv_kxk_acc #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 26,
  parameter int OFM_SIZE    = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int IN_CH       = 4,
  localparam int IFM_SIZE   = (OFM_SIZE - 1) * STRIDE + KERNEL_SIZE
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_WIDTH*IFM_SIZE*IFM_SIZE-1:0]    ifm,
  input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] kernel,
  input  logic [2*DATA_WIDTH-1:0]                    bias,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [ACC_WIDTH*OFM_SIZE*OFM_SIZE-1:0]     ofm,
  output logic [$clog2(IN_CH):0]                     ch_cnt
);

  localparam int NTAP  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX  = OFM_SIZE * OFM_SIZE;
  localparam int TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int CH_W  = $clog2(IN_CH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                                       state_r;
  logic [TAP_W-1:0]                             tap_r;
  logic [CH_W-1:0]                              ch_cnt_r;
  logic                                         in_ready_r;
  logic                                         out_valid_r;
  logic [DATA_WIDTH*IFM_SIZE*IFM_SIZE-1:0]      ifm_r;
  logic [DATA_WIDTH*NTAP-1:0]                   kernel_r;
  logic signed [ACC_WIDTH-1:0]                  acc_r     [NPIX];
  logic signed [ACC_WIDTH-1:0]                  acc_nxt_s [NPIX];
  logic signed [2*DATA_WIDTH-1:0]               prod_s    [NPIX];
  logic signed [DATA_WIDTH-1:0]                 win_s     [NPIX][NTAP];
  logic signed [DATA_WIDTH-1:0]                 kern_s    [NTAP];
  logic signed [ACC_WIDTH-1:0]                  bias_ext_s;

  // Clamp a one-bit-wider sum back into the accumulator range instead of wrapping.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] sum);
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      sat_acc = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sat_acc = sum[ACC_WIDTH-1:0];
    end
  endfunction

  assign bias_ext_s = ACC_WIDTH'($signed(bias));
  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign ch_cnt     = ch_cnt_r;

  // Each output pixel sees its own KxK window, so the per-tap pixel pick is pure wiring.
  for (genvar gp = 0; gp < NPIX; gp++) begin : g_pix
    for (genvar gt = 0; gt < NTAP; gt++) begin : g_tap
      localparam int ROW = (gp / OFM_SIZE) * STRIDE + gt / KERNEL_SIZE;
      localparam int COL = (gp % OFM_SIZE) * STRIDE + gt % KERNEL_SIZE;
      assign win_s[gp][gt] = ifm_r[(IFM_SIZE*ROW+COL)*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef CONV_RELU_EN
    assign ofm[gp*ACC_WIDTH +: ACC_WIDTH] = acc_r[gp][ACC_WIDTH-1] ? {ACC_WIDTH{1'b0}} : acc_r[gp];
`else
    assign ofm[gp*ACC_WIDTH +: ACC_WIDTH] = acc_r[gp];
`endif
  end

  for (genvar gk = 0; gk < NTAP; gk++) begin : g_kern
    assign kern_s[gk] = kernel_r[gk*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next accumulator value for the current tap: full-precision product, saturating add.
  always_comb begin
    for (int p = 0; p < NPIX; p++) begin
      prod_s[p]    = win_s[p][tap_r] * kern_s[tap_r];
      acc_nxt_s[p] = sat_acc((ACC_WIDTH+1)'(acc_r[p]) + (ACC_WIDTH+1)'(prod_s[p]));
    end
  end

  // Control FSM, operand latches and accumulator array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      tap_r       <= '0;
      ch_cnt_r    <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ifm_r       <= '0;
      kernel_r    <= '0;
      for (int p = 0; p < NPIX; p++) acc_r[p] <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            ifm_r      <= ifm;
            kernel_r   <= kernel;
            tap_r      <= '0;
            state_r    <= S_MAC;
            in_ready_r <= 1'b0;
            if (ch_cnt_r == '0) begin
              for (int p = 0; p < NPIX; p++) acc_r[p] <= bias_ext_s;
            end
          end
        end
        S_MAC: begin
          for (int p = 0; p < NPIX; p++) acc_r[p] <= acc_nxt_s[p];
          if (tap_r == TAP_W'(NTAP - 1)) begin
            ch_cnt_r <= ch_cnt_r + CH_W'(1);
            if (ch_cnt_r == CH_W'(IN_CH - 1)) begin
              state_r     <= S_DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r    <= S_IDLE;
              in_ready_r <= 1'b1;
            end
          end else begin
            tap_r <= tap_r + TAP_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            ch_cnt_r    <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          ch_cnt_r    <= '0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule
